regfile_2w_sb: RTL and testbench
================================

// Module: regfile_2w_sb
// PURPOSE
//   Parametrised integer register file for the pipelined CPU. Replaces the single-write-port,
//   negedge-write RF with a posedge-write file that has:
//     - two write ports (WB and late load-return);
//     - write-to-read bypass;
//     - a per-register busy scoreboard for hazard detection;
//     - a registered write-conflict flag;
//     - a debug read port.
//   Sits in ID (reads, busy query) and WB (writes).
// PARAMETERS
//   XLEN   32  data width of each register
//   NREG   32  number of registers; register 0 is hardwired to zero
//   AW     5   address width; must satisfy 2**AW >= NREG
// PORTS
//   clk       in   1     clock, all state updates on rising edge
//   rst       in   1     synchronous, active-high reset
//   A1        in   AW    read port 1 address (rs1)
//   A2        in   AW    read port 2 address (rs2)
//   RD1       out  XLEN  read port 1 data, combinational, bypassed
//   RD2       out  XLEN  read port 2 data, combinational, bypassed
//   busy1     out  1     rs1 has an outstanding producer
//   busy2     out  1     rs2 has an outstanding producer
//   we0       in   1     write enable, port 0 (WB)
//   wa0       in   AW    write address, port 0
//   wd0       in   XLEN  write data, port 0
//   we1       in   1     write enable, port 1 (load return); higher priority than port 0
//   wa1       in   AW    write address, port 1
//   wd1       in   XLEN  write data, port 1
//   sb_set    in   1     mark sb_addr busy (instruction issued with destination sb_addr)
//   sb_addr   in   AW    scoreboard set address
//   wr_conf   out  1     registered: both ports wrote the same nonzero address last cycle
//   sb_any    out  1     OR of all scoreboard bits (pipeline drain indicator)
//   reg_sel   in   AW    debug read address
//   reg_data  out  XLEN  debug read data, unbypassed array contents; 0 for reg_sel==0
// BEHAVIOUR
//   - Reset (rst=1 at posedge): all registers <= 0, all busy bits <= 0, wr_conf <= 0.
//     Write and set inputs in that cycle are ignored; reset wins over everything, including mid-burst.
//   - Writes: at posedge, if weN && waN!=0, rf[waN] <= wdN.
//     Same address on both ports: port 1 data is stored, and wr_conf is 1 in the following cycle.
//     wr_conf is 0 otherwise, and also when the shared address is 0.
//     Addresses >= NREG are ignored, both for writes and sb_set.
//   - Reads, for A in {A1, A2}:
//     - A==0: output 0.
//     - else if we1 && wa1==A: output wd1.
//     - else if we0 && wa0==A: output wd0.
//     - else: output rf[A].
//     - A >= NREG: output 0.
//     Zero-cycle latency; a write and a read of the same register in one cycle yields the new value.
//   - Scoreboard sb[NREG-1:0]: at posedge
//     - a write (either port) to addr X clears sb[X];
//     - sb_set sets sb[sb_addr];
//     - set wins over clear on the same address (a new producer issued);
//     - sb[0] is never set.
//   - busyK = sb[AK] && !(write this cycle to AK). A same-cycle sb_set is not visible until the next cycle.
//   - sb_any = |sb, registered-state based, with no bypass.
//   - reg_data reads the array only, so it lags bypass by one cycle.
// TESTING
//   1. rst=1 for 1 cycle, then A1=5, A2=31, reg_sel=7 -> RD1=0, RD2=0, reg_data=0, busy1=busy2=0, sb_any=0, wr_conf=0.
//   2. we0=1, wa0=3, wd0=32'hDEADBEEF, A1=3 in the same cycle -> RD1=32'hDEADBEEF in that cycle;
//      next cycle (no write) RD1=32'hDEADBEEF, reg_data(sel=3)=32'hDEADBEEF.
//   3. we0=1, wa0=0, wd0=32'h1234 -> RD1(A1=0)=0 and reg_data(0)=0 forever after; wr_conf stays 0.
//   4. we0=we1=1, wa0=wa1=9, wd0=32'h11, wd1=32'h22 -> same-cycle RD1(A1=9)=32'h22;
//      next cycle wr_conf=1, rf[9]=32'h22; cycle after, wr_conf=0.
//   5. sb_set=1, sb_addr=4 -> next cycle busy1(A1=4)=1, sb_any=1;
//      then we1=1, wa1=4 -> busy1=0 that cycle, sb[4]=0 next cycle, sb_any=0.
//   6. Simultaneous sb_set, sb_addr=6 and we0=1, wa0=6 -> sb[6]=1 afterwards.
//      Then rst=1 mid-operation with sb[6]=1 -> sb_any=0, rf[6]=0 next cycle.

Source files
------------

// File: rtl/regfile_2w_sb_if.sv
// Register-file bus: read/busy query ports, two write ports, scoreboard set and debug read.
// The master drives addresses and write data; the register file (slave) returns data and status.
interface regfile_2w_sb_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic [AW-1:0]   A1;
   logic [AW-1:0]   A2;
   logic [XLEN-1:0] RD1;
   logic [XLEN-1:0] RD2;
   logic            busy1;
   logic            busy2;
   logic            we0;
   logic [AW-1:0]   wa0;
   logic [XLEN-1:0] wd0;
   logic            we1;
   logic [AW-1:0]   wa1;
   logic [XLEN-1:0] wd1;
   logic            sb_set;
   logic [AW-1:0]   sb_addr;
   logic            wr_conf;
   logic            sb_any;
   logic [AW-1:0]   reg_sel;
   logic [XLEN-1:0] reg_data;

   modport master (
      output A1, A2, we0, wa0, wd0, we1, wa1, wd1, sb_set, sb_addr, reg_sel,
      input  RD1, RD2, busy1, busy2, wr_conf, sb_any, reg_data
   );

   modport slave (
      input  A1, A2, we0, wa0, wd0, we1, wa1, wd1, sb_set, sb_addr, reg_sel,
      output RD1, RD2, busy1, busy2, wr_conf, sb_any, reg_data
   );
endinterface

// File: rtl/regfile_2w_sb.sv
// Two-write-port integer register file with write-to-read bypass, busy scoreboard,
// registered same-address write-conflict flag and an unbypassed debug read port.
module regfile_2w_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input logic            clk,
   input logic            rst,
   regfile_2w_sb_if.slave rf_if
);

   logic [XLEN-1:0] rf_q [NREG];
   logic [NREG-1:0] sb_q, sb_d;
   logic            wr_conf_q, wr_conf_d;
   logic            wr0_ok, wr1_ok;

   // Register 0 and addresses beyond the file never hold state.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (a != '0) && (int'(a) < NREG);
   endfunction

   function automatic logic [XLEN-1:0] rd_mux(input logic [AW-1:0] a);
      if (!addr_ok(a))                     return '0;
      else if (rf_if.we1 && rf_if.wa1 == a) return rf_if.wd1;
      else if (rf_if.we0 && rf_if.wa0 == a) return rf_if.wd0;
      else                                  return rf_q[a];
   endfunction

   function automatic logic wr_hit(input logic [AW-1:0] a);
      return (wr0_ok && rf_if.wa0 == a) || (wr1_ok && rf_if.wa1 == a);
   endfunction

   assign wr0_ok    = rf_if.we0 && addr_ok(rf_if.wa0);
   assign wr1_ok    = rf_if.we1 && addr_ok(rf_if.wa1);
   assign wr_conf_d = wr0_ok && wr1_ok && (rf_if.wa0 == rf_if.wa1);

   // A newly issued producer must win over the retiring one on the same register.
   always_comb begin
      sb_d = sb_q;
      for (int i = 1; i < NREG; i++) begin
         if (wr_hit(AW'(i))) sb_d[i] = 1'b0;
         if (rf_if.sb_set && addr_ok(rf_if.sb_addr) && rf_if.sb_addr == AW'(i)) sb_d[i] = 1'b1;
      end
      sb_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
         sb_q      <= '0;
         wr_conf_q <= 1'b0;
      end else begin
         if (wr0_ok) rf_q[rf_if.wa0] <= rf_if.wd0;
         if (wr1_ok) rf_q[rf_if.wa1] <= rf_if.wd1;
         sb_q      <= sb_d;
         wr_conf_q <= wr_conf_d;
      end
   end

   always_comb begin
      rf_if.RD1   = rd_mux(rf_if.A1);
      rf_if.RD2   = rd_mux(rf_if.A2);
      rf_if.busy1 = addr_ok(rf_if.A1) && sb_q[rf_if.A1] && !wr_hit(rf_if.A1);
      rf_if.busy2 = addr_ok(rf_if.A2) && sb_q[rf_if.A2] && !wr_hit(rf_if.A2);
      rf_if.reg_data = addr_ok(rf_if.reg_sel) ? rf_q[rf_if.reg_sel] : '0;
   end

   assign rf_if.wr_conf = wr_conf_q;
   assign rf_if.sb_any  = |sb_q;

endmodule

// File: tb/tb_regfile_2w_sb.sv
// Directed bench for regfile_2w_sb: reset, bypass, x0, dual-write conflict, scoreboard, reset.
module tb_regfile_2w_sb;
   logic clk = 1'b0;
   logic rst;
   int   n_chk = 0;
   int   n_fail = 0;

   regfile_2w_sb_if #(.XLEN(32), .AW(5)) bus ();

   regfile_2w_sb #(.XLEN(32), .NREG(32), .AW(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .rf_if (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.we0 = 0; bus.wa0 = 0; bus.wd0 = 0;
      bus.we1 = 0; bus.wa1 = 0; bus.wd1 = 0;
      bus.sb_set = 0; bus.sb_addr = 0;
   endtask

   initial begin
      idle();
      bus.A1 = 0; bus.A2 = 0; bus.reg_sel = 0;
      rst = 1;
      tick();
      rst = 0;

      // reset state
      bus.A1 = 5; bus.A2 = 31; bus.reg_sel = 7;
      #1;
      chk("rst_rd1", bus.RD1, 0);
      chk("rst_rd2", bus.RD2, 0);
      chk("rst_regdata", bus.reg_data, 0);
      chk("rst_busy1", 32'(bus.busy1), 0);
      chk("rst_busy2", 32'(bus.busy2), 0);
      chk("rst_sbany", 32'(bus.sb_any), 0);
      chk("rst_wrconf", 32'(bus.wr_conf), 0);

      // write with same-cycle bypass
      bus.we0 = 1; bus.wa0 = 3; bus.wd0 = 32'hDEADBEEF; bus.A1 = 3;
      #1 chk("byp_rd1", bus.RD1, 32'hDEADBEEF);
      tick(); idle(); bus.reg_sel = 3;
      #1;
      chk("stored_rd1", bus.RD1, 32'hDEADBEEF);
      chk("stored_regdata", bus.reg_data, 32'hDEADBEEF);

      // writes to x0 are discarded
      bus.we0 = 1; bus.wa0 = 0; bus.wd0 = 32'h1234; bus.A1 = 0; bus.reg_sel = 0;
      #1 chk("x0_byp", bus.RD1, 0);
      tick(); idle();
      #1;
      chk("x0_rd1", bus.RD1, 0);
      chk("x0_regdata", bus.reg_data, 0);
      chk("x0_wrconf", 32'(bus.wr_conf), 0);

      // same address on both ports: port 1 wins, conflict flagged next cycle
      bus.we0 = 1; bus.wa0 = 9; bus.wd0 = 32'h11;
      bus.we1 = 1; bus.wa1 = 9; bus.wd1 = 32'h22; bus.A1 = 9;
      #1 chk("conf_byp", bus.RD1, 32'h22);
      tick(); idle(); bus.reg_sel = 9;
      #1;
      chk("conf_flag", 32'(bus.wr_conf), 1);
      chk("conf_regdata", bus.reg_data, 32'h22);
      tick();
      chk("conf_clear", 32'(bus.wr_conf), 0);

      // distinct addresses on both ports: both stored, no conflict
      bus.we0 = 1; bus.wa0 = 10; bus.wd0 = 32'hA0A0;
      bus.we1 = 1; bus.wa1 = 11; bus.wd1 = 32'hB1B1;
      bus.A1 = 10; bus.A2 = 11;
      #1;
      chk("dual_byp1", bus.RD1, 32'hA0A0);
      chk("dual_byp2", bus.RD2, 32'hB1B1);
      tick(); idle();
      #1;
      chk("dual_noconf", 32'(bus.wr_conf), 0);
      chk("dual_rd1", bus.RD1, 32'hA0A0);
      chk("dual_rd2", bus.RD2, 32'hB1B1);

      // both ports to x0: no conflict
      bus.we0 = 1; bus.we1 = 1; bus.wa0 = 0; bus.wa1 = 0;
      tick(); idle();
      #1 chk("x0_dual_noconf", 32'(bus.wr_conf), 0);

      // scoreboard set, then clear by a port-1 write
      bus.sb_set = 1; bus.sb_addr = 4; bus.A1 = 4;
      #1 chk("sb_set_notyet", 32'(bus.busy1), 0);
      tick(); idle();
      #1;
      chk("sb_busy1", 32'(bus.busy1), 1);
      chk("sb_any_set", 32'(bus.sb_any), 1);
      bus.we1 = 1; bus.wa1 = 4; bus.wd1 = 32'h55;
      #1 chk("sb_busy_wr", 32'(bus.busy1), 0);
      tick(); idle();
      #1;
      chk("sb_cleared", 32'(bus.busy1), 0);
      chk("sb_any_clr", 32'(bus.sb_any), 0);

      // set wins over clear on the same address
      bus.sb_set = 1; bus.sb_addr = 6; bus.we0 = 1; bus.wa0 = 6; bus.wd0 = 32'h66;
      tick(); idle(); bus.A1 = 6; bus.A2 = 6; bus.reg_sel = 6;
      #1;
      chk("setwin_busy", 32'(bus.busy2), 1);
      chk("setwin_any", 32'(bus.sb_any), 1);
      chk("setwin_rd", bus.RD1, 32'h66);

      // reset mid-operation, with a write that must be ignored
      rst = 1; bus.we0 = 1; bus.wa0 = 6; bus.wd0 = 32'h77; bus.sb_set = 1; bus.sb_addr = 7;
      tick(); rst = 0; idle();
      #1;
      chk("rst2_any", 32'(bus.sb_any), 0);
      chk("rst2_regdata", bus.reg_data, 0);
      chk("rst2_rd1", bus.RD1, 0);
      chk("rst2_busy", 32'(bus.busy1), 0);
      bus.reg_sel = 3;
      #1 chk("rst2_r3", bus.reg_data, 0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
